// File: rtl/ped_request_unit.sv
// -----------------------------------------------------------------------------
// ped_request_unit
//
// Pedestrian push-button front end for a traffic light controller. The raw
// button is synchronized, debounced into single press events, and turned into
// a held crossing request. The unit tracks served walk phases, enforces a
// cooldown after each walk, and flags request timeouts and walk/lamp conflicts.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized-high cycles that qualify a press
//   COOLDOWN_CYCLES : cycles after a served walk before a new request is issued
//   TIMEOUT_CYCLES  : cycles a request may wait for walk before timeout_err
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous reset, active low
//   btn          : raw asynchronous push-button, 1 = pressed
//   walk         : walk indication from the traffic light controller
//   light        : controller lamp state (00 red, 01 yellow, 10 green)
//   ped          : crossing request to the controller
//   wait_lamp    : "request pending" lamp on the button unit
//   served_cnt   : completed walk phases, saturating at 255
//   timeout_err  : one-cycle pulse when a request has waited too long
//   conflict_err : sticky flag, walk seen while light is not red
// -----------------------------------------------------------------------------
module ped_request_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       walk,
    input  logic [1:0] light,
    output logic       ped,
    output logic       wait_lamp,
    output logic [7:0] served_cnt,
    output logic       timeout_err,
    output logic       conflict_err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVE,
        COOLDOWN
    } state_t;

    state_t          state;
    logic            btn_sync_p0;
    logic            btn_sync_p1;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic [TO_W-1:0] wait_cnt;
    logic [CD_W-1:0] cd_cnt;
    logic            pending;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        sat_inc8 = (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizer on the raw button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
        end else begin
            btn_sync_p0 <= btn;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

    // Debounce stage: saturating run-length counter. The press pulse fires only
    // on the transition into saturation, so a held button yields one event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= btn_sync_p1 && (db_cnt == DB_LAST);
            if (!btn_sync_p1) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Request FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ped         <= 1'b0;
            wait_lamp   <= 1'b0;
            served_cnt  <= 8'd0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            cd_cnt      <= '0;
            pending     <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    ped       <= 1'b0;
                    wait_lamp <= 1'b0;
                    if (press) begin
                        state     <= REQ;
                        ped       <= 1'b1;
                        wait_lamp <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (walk) begin
                        state     <= SERVE;
                        ped       <= 1'b0;
                        wait_lamp <= 1'b0;
                    end else if (wait_cnt == TO_LAST) begin
                        // Keep requesting; the error only reports the stall.
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                SERVE: begin
                    if (!walk) begin
                        state      <= COOLDOWN;
                        served_cnt <= sat_inc8(served_cnt);
                        cd_cnt     <= '0;
                        pending    <= 1'b0;
                        wait_lamp  <= 1'b0;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == CD_LAST) begin
                        // A press landing on the expiry cycle still counts.
                        pending <= 1'b0;
                        if (pending || press) begin
                            state     <= REQ;
                            ped       <= 1'b1;
                            wait_lamp <= 1'b1;
                            wait_cnt  <= '0;
                        end else begin
                            state     <= IDLE;
                            wait_lamp <= 1'b0;
                        end
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                        if (press) begin
                            pending   <= 1'b1;
                            wait_lamp <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ped       <= 1'b0;
                    wait_lamp <= 1'b0;
                end
            endcase
        end
    end

    // Conflict monitor, independent of the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_err <= 1'b0;
        end else if (walk && (light != 2'b00)) begin
            conflict_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ped_request_unit.sv
// -----------------------------------------------------------------------------
// tb_ped_request_unit
//
// Scenario bench for ped_request_unit with default parameters. Each task
// pushes the expected output vector per cycle into a queue as it drives the
// stimulus, then pops and compares against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_ped_request_unit;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       walk;
    logic [1:0] light;
    logic       ped;
    logic       wait_lamp;
    logic [7:0] served_cnt;
    logic       timeout_err;
    logic       conflict_err;

    int checks;
    int errors;
    int exp_served;

    typedef struct packed {
        logic       ped;
        logic       wl;
        logic [7:0] cnt;
        logic       tmo;
        logic       cfl;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cnt_q[$];

    ped_request_unit dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .walk         (walk),
        .light        (light),
        .ped          (ped),
        .wait_lamp    (wait_lamp),
        .served_cnt   (served_cnt),
        .timeout_err  (timeout_err),
        .conflict_err (conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic p, input logic w, input int s,
                                input logic t, input logic c);
        exp_t e;
        e.ped = p;
        e.wl  = w;
        e.cnt = 8'(s);
        e.tmo = t;
        e.cfl = c;
        return e;
    endfunction

    function automatic exp_t obs();
        return mk(ped, wait_lamp, int'(served_cnt), timeout_err, conflict_err);
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("ped=%b wl=%b cnt=%0d tmo=%b cfl=%b",
                         e.ped, e.wl, e.cnt, e.tmo, e.cfl);
    endfunction

    task automatic test_reset();
        exp_t e;
        exp_t got;
        exp_q.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        e   = exp_q.pop_front();
        got = obs();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_state: got %s expected %s", fmt(got), fmt(e));
        end
        rst = 1'b1;
    endtask

    // btn held from the first edge after reset release: ped/wait_lamp at edge 7
    task automatic test_press_latency();
        exp_t e;
        exp_t got;
        btn = 1'b1;
        for (int k = 1; k <= 10; k++)
            exp_q.push_back(mk(k >= 7, k >= 7, 0, 1'b0, 1'b0));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL press_latency edge %0d: got %s expected %s", k, fmt(got), fmt(e));
            end
        end
    endtask

    // walk for 3 cycles, then 0; btn stays held so no second request may appear
    task automatic test_serve();
        exp_t e;
        exp_t got;
        light = 2'b00;
        walk  = 1'b1;
        for (int i = 1; i <= 20; i++)
            exp_q.push_back(mk(1'b0, 1'b0, (i >= 4) ? 1 : 0, 1'b0, 1'b0));
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL serve cyc %0d: got %s expected %s", i, fmt(got), fmt(e));
            end
            walk = (i < 3);
        end
        exp_served = 1;
        btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // press lands in COOLDOWN: wait_lamp at C+6, REQ with ped at C+8
    task automatic test_cooldown_press();
        exp_t e;
        exp_t got;
        bit   found;
        btn   = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (ped === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL cooldown_req_wait: got ped=%b expected ped=1 within 20 cycles", ped);
        end
        walk = 1'b1;
        btn  = 1'b0;
        repeat (3) @(negedge clk);
        walk = 1'b0;
        btn  = 1'b1;
        for (int i = 0; i <= 12; i++)
            exp_q.push_back(mk(i >= 8, i >= 6, exp_served + 1, 1'b0, 1'b0));
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cooldown_press cyc %0d: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
        exp_served++;
        btn  = 1'b0;
        walk = 1'b1;
        @(negedge clk);
        walk = 1'b0;
        cnt_q.push_back(8'(exp_served + 1));
        @(negedge clk);
        exp_served++;
        checks++;
        if (served_cnt !== cnt_q[0]) begin
            errors++;
            $display("FAIL cooldown_serve_cnt: got %0d expected %0d", served_cnt, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
        repeat (10) @(negedge clk);
    endtask

    // raw btn 1,1,1,0 then held: only the 4th 1 of the final run qualifies
    task automatic test_bounce();
        exp_t e;
        exp_t got;
        for (int i = 1; i <= 14; i++)
            exp_q.push_back(mk(i >= 11, i >= 11, exp_served, 1'b0, 1'b0));
        for (int i = 1; i <= 14; i++) begin
            btn = (i != 4);
            @(negedge clk);
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL bounce edge %0d: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    // reset while in REQ drops ped at once; held btn then re-qualifies fresh
    task automatic test_reset_mid();
        exp_t e;
        exp_t got;
        rst = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b0));
        #1;
        e   = exp_q.pop_front();
        got = obs();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_mid_async: got %s expected %s", fmt(got), fmt(e));
        end
        exp_served = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 9; i++)
            exp_q.push_back(mk(i >= 7, i >= 7, 0, 1'b0, 1'b0));
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_refresh edge %0d: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    // REQ entered at edge 7; timeout pulses at entry+32 and entry+64
    task automatic test_timeout();
        exp_t e;
        exp_t got;
        int   pulses;
        rst  = 1'b0;
        btn  = 1'b0;
        walk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        btn = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 75; i++)
            exp_q.push_back(mk(i >= 7, i >= 7, 0, (i == 39) || (i == 71), 1'b0));
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) pulses++;
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout edge %0d: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL timeout_pulse_count: got %0d expected 2", pulses);
        end
    endtask

    // walk in IDLE with red is harmless; walk with green sets a sticky flag
    task automatic test_conflict();
        exp_t e;
        exp_t got;
        rst  = 1'b0;
        btn  = 1'b0;
        walk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        walk  = 1'b1;
        light = 2'b00;
        exp_q.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b0));
        @(negedge clk);
        e   = exp_q.pop_front();
        got = obs();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL walk_red_idle: got %s expected %s", fmt(got), fmt(e));
        end
        light = 2'b10;
        for (int i = 1; i <= 9; i++)
            exp_q.push_back(mk(1'b0, 1'b0, 0, 1'b0, 1'b1));
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            walk  = 1'b0;
            light = 2'b00;
            e   = exp_q.pop_front();
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL conflict cyc %0d: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (conflict_err !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear: got %b expected 0", conflict_err);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // 256 full serves: counter climbs to 255 and holds there
    task automatic test_saturation();
        bit found;
        for (int n = 1; n <= 256; n++) begin
            btn   = 1'b1;
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge clk);
                if (ped === 1'b1) found = 1'b1;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL sat_req_wait serve %0d: got ped=%b expected ped=1 within 20 cycles", n, ped);
            end
            btn  = 1'b0;
            walk = 1'b1;
            @(negedge clk);
            walk = 1'b0;
            cnt_q.push_back((n >= 255) ? 8'd255 : 8'(n));
            @(negedge clk);
            checks++;
            if (served_cnt !== cnt_q[0]) begin
                errors++;
                $display("FAIL sat_served_cnt serve %0d: got %0d expected %0d", n, served_cnt, cnt_q[0]);
            end
            void'(cnt_q.pop_front());
            repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_served = 0;
        rst        = 1'b0;
        btn        = 1'b0;
        walk       = 1'b0;
        light      = 2'b00;
        test_reset();
        test_press_latency();
        test_serve();
        test_cooldown_press();
        test_bounce();
        test_reset_mid();
        test_timeout();
        test_conflict();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
